// File: rtl/lcd_write_controller.sv
// rtl/lcd_write_controller.sv - 4-bit character LCD write controller with autonomous power-on init
module lcd_write_controller #(
    parameter int POWERON_CYCLES       = 750000,
    parameter int SETUP_CYCLES         = 2,
    parameter int E_HIGH_CYCLES        = 12,
    parameter int GAP_CYCLES           = 50,
    parameter int INIT_NIB_WAIT_CYCLES = 205000,
    parameter int BYTE_WAIT_CYCLES     = 2000,
    parameter int CLEAR_WAIT_CYCLES    = 82000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iLCD_Write,
    input  logic [7:0] iLCD_Data,
    input  logic       iLCD_RS,
    output logic       oLCD_Ready,
    output logic [3:0] oLCD_Data,
    output logic       oLCD_RS,
    output logic       oLCD_RW,
    output logic       oLCD_E
);

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAXC = imax(imax(imax(POWERON_CYCLES, SETUP_CYCLES), imax(E_HIGH_CYCLES, GAP_CYCLES)),
                               imax(imax(INIT_NIB_WAIT_CYCLES, BYTE_WAIT_CYCLES), CLEAR_WAIT_CYCLES));
    localparam int CW = $clog2(MAXC + 1);

    localparam logic [CW-1:0] C_POWERON = CW'(POWERON_CYCLES - 1);
    localparam logic [CW-1:0] C_SETUP   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] C_EHIGH   = CW'(E_HIGH_CYCLES - 1);
    localparam logic [CW-1:0] C_GAP     = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] C_NIBWAIT = CW'(INIT_NIB_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] C_BYTE    = CW'(BYTE_WAIT_CYCLES - 1);
    localparam logic [CW-1:0] C_CLEAR   = CW'(CLEAR_WAIT_CYCLES - 1);

    // Entries 0-3: init nibbles (low bits); entries 4-7: init command bytes.
    localparam logic [7:0] INIT_SEQ [8] = '{8'h03, 8'h03, 8'h03, 8'h02,
                                            8'h28, 8'h06, 8'h0C, 8'h01};

    typedef enum logic [3:0] {
        S_POWERON, S_INIT_NIB, S_INIT_CMD, S_IDLE,
        S_SETUP_H, S_EHI_H, S_GAP, S_SETUP_L, S_EHI_L, S_POST
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      idx;
    logic [1:0]      nib_phase;
    logic [7:0]      byte_q;
    logic            rs_q;
    logic            init_cmd;
    logic [1:0]      nxt_idx;
    logic            is_clear;

    assign nxt_idx  = idx + 2'd1;
    assign is_clear = (byte_q == 8'h01) && !rs_q;
    assign oLCD_RW  = 1'b0;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state      <= S_POWERON;
            cnt        <= '0;
            idx        <= 2'd0;
            nib_phase  <= 2'd0;
            byte_q     <= 8'h00;
            rs_q       <= 1'b0;
            init_cmd   <= 1'b0;
            oLCD_Ready <= 1'b0;
            oLCD_Data  <= 4'h0;
            oLCD_RS    <= 1'b0;
            oLCD_E     <= 1'b0;
        end else begin
            case (state)
                // The only up-counting phase: reset clears the counter rather than preloading it.
                S_POWERON: begin
                    if (cnt == C_POWERON) begin
                        state     <= S_INIT_NIB;
                        nib_phase <= 2'd0;
                        idx       <= 2'd0;
                        oLCD_Data <= INIT_SEQ[0][3:0];
                        oLCD_RS   <= 1'b0;
                        cnt       <= C_SETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INIT_NIB: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        case (nib_phase)
                            2'd0: begin
                                oLCD_E    <= 1'b1;
                                cnt       <= C_EHIGH;
                                nib_phase <= 2'd1;
                            end
                            2'd1: begin
                                oLCD_E    <= 1'b0;
                                cnt       <= C_NIBWAIT;
                                nib_phase <= 2'd2;
                            end
                            default: begin
                                nib_phase <= 2'd0;
                                cnt       <= C_SETUP;
                                if (idx == 2'd3) begin
                                    state     <= S_SETUP_H;
                                    idx       <= 2'd0;
                                    init_cmd  <= 1'b1;
                                    byte_q    <= INIT_SEQ[4];
                                    rs_q      <= 1'b0;
                                    oLCD_Data <= INIT_SEQ[4][7:4];
                                end else begin
                                    idx       <= nxt_idx;
                                    oLCD_Data <= INIT_SEQ[{1'b0, nxt_idx}][3:0];
                                end
                            end
                        endcase
                    end
                end
                S_IDLE: begin
                    if (iLCD_Write) begin
                        state      <= S_SETUP_H;
                        byte_q     <= iLCD_Data;
                        rs_q       <= iLCD_RS;
                        init_cmd   <= 1'b0;
                        oLCD_Data  <= iLCD_Data[7:4];
                        oLCD_RS    <= iLCD_RS;
                        oLCD_Ready <= 1'b0;
                        cnt        <= C_SETUP;
                    end
                end
                S_SETUP_H, S_SETUP_L: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= (state == S_SETUP_H) ? S_EHI_H : S_EHI_L;
                        oLCD_E <= 1'b1;
                        cnt    <= C_EHIGH;
                    end
                end
                S_EHI_H: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= S_GAP;
                        oLCD_E <= 1'b0;
                        cnt    <= C_GAP;
                    end
                end
                // Low nibble appears only after the gap, so data never moves as E falls.
                S_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= S_SETUP_L;
                        oLCD_Data <= byte_q[3:0];
                        cnt       <= C_SETUP;
                    end
                end
                S_EHI_L: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= init_cmd ? S_INIT_CMD : S_POST;
                        oLCD_E <= 1'b0;
                        cnt    <= is_clear ? C_CLEAR : C_BYTE;
                    end
                end
                // Post-wait of an init command byte; also steps to the next command.
                S_INIT_CMD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (idx == 2'd3) begin
                        state      <= S_IDLE;
                        init_cmd   <= 1'b0;
                        oLCD_Ready <= 1'b1;
                    end else begin
                        state     <= S_SETUP_H;
                        idx       <= nxt_idx;
                        byte_q    <= INIT_SEQ[{1'b1, nxt_idx}];
                        oLCD_Data <= INIT_SEQ[{1'b1, nxt_idx}][7:4];
                        cnt       <= C_SETUP;
                    end
                end
                S_POST: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= S_IDLE;
                        oLCD_Ready <= 1'b1;
                    end
                end
                default: state <= S_POWERON;
            endcase
        end
    end

endmodule

// File: doc/lcd_write_controller.md
# lcd_write_controller

Downstream consumer of the `LCD` instruction and producer of the LCD-ready flag tested by `BNLCD`. Accepts one 8-bit character/command per handshake from the processor core and drives a character LCD in 4-bit mode as two nibble transfers with parameterised setup, enable-pulse and settle timing. After reset it runs the controller power-on initialisation autonomously. `oLCD_Ready` stays low until initialisation completes.

## Interface
Parameters (in clock cycles):
- `POWERON_CYCLES`, 750000: idle wait after reset before the first init nibble (15 ms at 50 MHz).
- `SETUP_CYCLES`, 2: RS/data valid with E low before each E pulse.
- `E_HIGH_CYCLES`, 12: E high width per nibble.
- `GAP_CYCLES`, 50: E low between the high and low nibble of a byte.
- `INIT_NIB_WAIT_CYCLES`, 205000: E low after each init nibble.
- `BYTE_WAIT_CYCLES`, 2000: E low after a byte, before ready.
- `CLEAR_WAIT_CYCLES`, 82000: replaces `BYTE_WAIT_CYCLES` after command 0x01 (RS=0).

Ports:
- `Clock` in 1: system clock, rising edge.
- `Reset` in 1: synchronous, active-low.
- `iLCD_Write` in 1: write strobe, sampled only while `oLCD_Ready`=1.
- `iLCD_Data` in 8: character or command byte.
- `iLCD_RS` in 1: 1=data register, 0=instruction register.
- `oLCD_Ready` out 1: 1=idle, write accepted this cycle.
- `oLCD_Data` out 4: LCD DB[7:4].
- `oLCD_RS` out 1: LCD register select.
- `oLCD_RW` out 1: constant 0 (write only).
- `oLCD_E` out 1: LCD enable.

## Operation
- Reset (`Reset`=0 at a rising edge): every output is 0, state is `S_POWERON`, and the counter is cleared. This applies from any state. Reset mid-transfer abandons the transfer, and the full init repeats.
- Nibble transfer, shared sub-sequence:
  - `SETUP_CYCLES` cycles with `oLCD_Data`/`oLCD_RS` valid and E=0.
  - Then `E_HIGH_CYCLES` cycles with E=1, data/RS held.
  - Data/RS stay held through the following wait phase.
- Byte transfer: high nibble `[7:4]` → `GAP_CYCLES` → low nibble `[3:0]` → post-wait. The post-wait is `CLEAR_WAIT_CYCLES` if the byte is 0x01 with RS=0, otherwise `BYTE_WAIT_CYCLES`.
- States:
  - `S_POWERON`: count `POWERON_CYCLES`, then go to `S_INIT_NIB`.
  - `S_INIT_NIB`: nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. Each is followed by `INIT_NIB_WAIT_CYCLES`.
  - `S_INIT_CMD`: bytes 0x28, 0x06, 0x0C, 0x01 with RS=0, using normal byte transfers.
  - `S_IDLE`: `oLCD_Ready`=1, outputs E=0 and data/RS hold their last value.
  - `S_SETUP_H`, `S_EHI_H`, `S_GAP`, `S_SETUP_L`, `S_EHI_L`, `S_POST`: then return to `S_IDLE`.
- Handshake: a write is accepted at a rising edge where `iLCD_Write`=1 and `oLCD_Ready`=1.
  - `iLCD_Data` and `iLCD_RS` are captured into internal registers on that edge. Inputs may change afterwards.
  - `iLCD_Write` while not ready is ignored, with no queuing.
  - Holding `iLCD_Write` high produces one write per ready window.
- Init index counters are 2-bit and select from a fixed 8-entry sequence. Phase counters are wide enough for the largest parameter, load to N-1, and count down to 0, so each phase lasts exactly N cycles (N≥1).

## Timing
- Cycle 0 is the first rising edge with `Reset`=1. Phases occupy consecutive cycles with no idle cycles between them.
- Init length is P + 4·(S+H+W_i) + 3·(2(S+H)+G+W_b) + (2(S+H)+G+W_c), where:
  - P = `POWERON_CYCLES`, S = `SETUP_CYCLES`, H = `E_HIGH_CYCLES`, G = `GAP_CYCLES`
  - W_i = `INIT_NIB_WAIT_CYCLES`, W_b = `BYTE_WAIT_CYCLES`, W_c = `CLEAR_WAIT_CYCLES`
  - `oLCD_Ready` goes high in the cycle after the final wait.
- Accepted write at edge k: `oLCD_Ready`=0 from k+1. The first setup cycle is k+1. `oLCD_Ready` returns to 1 after 2(S+H)+G+post-wait busy cycles.
- `oLCD_E` rises only after ≥S cycles of stable data/RS. Data/RS never change while E=1 or in the cycle E falls.
- `oLCD_RW`=0 at all times, including reset.

## Test plan
Bench parameters: P=20, S=2, H=4, G=3, W_i=8, W_b=10, W_c=40.
1. Reset release → `oLCD_Ready` first 1 at cycle 206. E pulse sequence:
   - four 4-cycle pulses with nibbles 3, 3, 3, 2
   - then pulse pairs 2/8, 0/6, 0/C, 0/1
   - RS=0 and RW=0 throughout.
2. Write 0x48, RS=1 (`H`) → `oLCD_Ready` low for exactly 25 cycles. E pulses carry 0x4 then 0x8 with RS=1. There are 3 E-low cycles between the pulses.
3. Write 0x01, RS=0 → busy 55 cycles. Write 0x01, RS=1 → busy 25 cycles.
4. `iLCD_Write` pulsed every cycle during a busy period with changing data → only the accepted byte appears on the bus. Exactly one transfer occurs per ready window.
5. `Reset`=0 during the E-high of a low nibble → next cycle all outputs are 0. After release, the full 206-cycle init repeats before ready.
6. Four back-to-back writes `H`, `O`, `L`, `A` (RS=1), each issued on the first ready cycle → nibble streams 4/8, 4/F, 4/C, 4/1. Ready returns every 25 cycles.
